arithmetic_unit: RTL and testbench

ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

---
 rtl/arith_pkg.sv | 15 +
 rtl/arithmetic_unit_if.sv | 29 ++
 rtl/arith_divider.sv | 84 ++++++++
 rtl/arithmetic_unit.sv | 114 +++++++++++
 tb/tb_arithmetic_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and divider state type for arithmetic_unit
package arith_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Sliced to WIDTH at the point of use; wide enough for any practical operand width.
   localparam logic [31:0] DIV0_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_state_t;

endpackage

// File: rtl/arithmetic_unit_if.sv
// rtl/arithmetic_unit_if.sv - operand/result bundle between a requester and arithmetic_unit
interface arithmetic_unit_if
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   ym;
   logic [WIDTH-1:0]     ya;
   logic [WIDTH-1:0]     ys;
   logic [WIDTH-1:0]     yd;
   logic [WIDTH-1:0]     ymod;
   logic                 div_by_zero;
   logic                 out_valid;

   modport master (
      output in_valid, a, b,
      input  in_ready, ym, ya, ys, yd, ymod, div_by_zero, out_valid
   );

   modport slave (
      input  in_valid, a, b,
      output in_ready, ym, ya, ys, yd, ymod, div_by_zero, out_valid
   );

endinterface

// File: rtl/arith_divider.sv
// rtl/arith_divider.sv - restoring divider, one quotient bit per cycle
// Compiled only with ARITH_DIV_EN defined.
`ifdef ARITH_DIV_EN
module arith_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state, next_state;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0] cnt_q;

   logic             load;
   logic [WIDTH-1:0] step_rem, step_quo, step_dvs;
   logic [WIDTH:0]   trial, diff;
   logic             ge;
   logic [WIDTH-1:0] new_rem, new_quo;

   // The first quotient bit is produced on the load edge so the last one lands
   // WIDTH-1 edges later, leaving the DONE cycle for the top to register results.
   assign load     = (state == IDLE) && start;
   assign step_rem = load ? '0 : rem_q;
   assign step_quo = load ? dividend : quo_q;
   assign step_dvs = load ? divisor : dvs_q;

   assign trial   = {step_rem, step_quo[WIDTH-1]};
   assign diff    = trial - {1'b0, step_dvs};
   assign ge      = trial >= {1'b0, step_dvs};
   assign new_rem = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign new_quo = (step_quo << 1) | WIDTH'(ge);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = (WIDTH == 1) ? DONE : BUSY;
         BUSY: if (cnt_q == CNT_W'(1)) next_state = DONE;
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= new_rem;
         quo_q <= new_quo;
         dvs_q <= divisor;
         cnt_q <= CNT_W'(WIDTH - 1);
      end else if (state == BUSY) begin
         rem_q <= new_rem;
         quo_q <= new_quo;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule
`endif

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - registered add/sub/mul with optional iterative divide
// Optional divider enabled by defining ARITH_DIV_EN.
module arithmetic_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   arithmetic_unit_if.slave bus
);
   logic [WIDTH-1:0]   sum_w, diff_w;
   logic [2*WIDTH-1:0] prod_w;
   logic               accept;

   logic [2*WIDTH-1:0] ym_q;
   logic [WIDTH-1:0]   ya_q, ys_q;
   logic               out_valid_q;

   assign sum_w  = bus.a + bus.b;
   assign diff_w = bus.a - bus.b;
   assign prod_w = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
   assign accept = bus.in_valid && bus.in_ready;

   assign bus.ym        = ym_q;
   assign bus.ya        = ya_q;
   assign bus.ys        = ys_q;
   assign bus.out_valid = out_valid_q;

`ifdef ARITH_DIV_EN
   logic               busy_q;
   logic [2*WIDTH-1:0] ym_p;
   logic [WIDTH-1:0]   ya_p, ys_p;
   logic               dbz_p;
   logic [WIDTH-1:0]   yd_q, ymod_q;
   logic               dbz_q;
   logic [WIDTH-1:0]   quotient, remainder;
   logic               div_done;

   arith_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept),
      .dividend  (bus.a),
      .divisor   (bus.b),
      .quotient  (quotient),
      .remainder (remainder),
      .done      (div_done)
   );

   assign bus.in_ready    = !busy_q;
   assign bus.yd          = yd_q;
   assign bus.ymod        = ymod_q;
   assign bus.div_by_zero = dbz_q;

   // add/sub/mul are parked at capture and released together with the quotient.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= 1'b0;
         ym_p        <= '0;
         ya_p        <= '0;
         ys_p        <= '0;
         dbz_p       <= 1'b0;
         ym_q        <= '0;
         ya_q        <= '0;
         ys_q        <= '0;
         yd_q        <= '0;
         ymod_q      <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= div_done;
         if (accept) begin
            busy_q <= 1'b1;
            ym_p   <= prod_w;
            ya_p   <= sum_w;
            ys_p   <= diff_w;
            dbz_p  <= (bus.b == '0);
         end
         if (div_done) begin
            busy_q <= 1'b0;
            ym_q   <= ym_p;
            ya_q   <= ya_p;
            ys_q   <= ys_p;
            yd_q   <= dbz_p ? DIV0_QUOTIENT[WIDTH-1:0] : quotient;
            ymod_q <= remainder;
            dbz_q  <= dbz_p;
         end
      end
   end
`else
   assign bus.in_ready    = 1'b1;
   assign bus.yd          = '0;
   assign bus.ymod        = '0;
   assign bus.div_by_zero = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ym_q        <= '0;
         ya_q        <= '0;
         ys_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= accept;
         if (accept) begin
            ym_q <= prod_w;
            ya_q <= sum_w;
            ys_q <= diff_w;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb/tb_arithmetic_unit.sv - directed vector bench for arithmetic_unit (either ARITH_DIV_EN build)
module tb_arithmetic_unit;
   import arith_pkg::*;

   localparam int W = 4;
`ifdef ARITH_DIV_EN
   localparam int LAT    = W + 1;
   localparam bit DIV_ON = 1'b1;
`else
   localparam int LAT    = 1;
   localparam bit DIV_ON = 1'b0;
`endif
   localparam int RST_DLY = (LAT == 1) ? 0 : 2;

   typedef struct {
      logic [3:0] a, b;
      logic [3:0] ya, ys;
      logic [7:0] ym;
      logic [3:0] yd, ymod;
      logic       dbz;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   arithmetic_unit_if #(.WIDTH(W)) bus ();
   arithmetic_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input int a, b, ya, ys, ym, yd, ymod, dbz);
      vec_t v;
      v.a = 4'(a); v.b = 4'(b); v.ya = 4'(ya); v.ys = 4'(ys); v.ym = 8'(ym);
      v.yd   = DIV_ON ? 4'(yd) : 4'd0;
      v.ymod = DIV_ON ? 4'(ymod) : 4'd0;
      v.dbz  = DIV_ON ? 1'(dbz) : 1'b0;
      return v;
   endfunction

   task automatic check_results(input string tag, input vec_t v);
      check({tag, " ya"}, 32'(bus.ya), 32'(v.ya));
      check({tag, " ys"}, 32'(bus.ys), 32'(v.ys));
      check({tag, " ym"}, 32'(bus.ym), 32'(v.ym));
      check({tag, " yd"}, 32'(bus.yd), 32'(v.yd));
      check({tag, " ymod"}, 32'(bus.ymod), 32'(v.ymod));
      check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(v.dbz));
   endtask

   task automatic apply(input vec_t v, input string tag);
      int n;
      @(negedge clk);
      check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
      bus.a = v.a;
      bus.b = v.b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      check({tag, " in_ready after capture"}, 32'(bus.in_ready), (LAT == 1) ? 32'd1 : 32'd0);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(LAT));
      check({tag, " in_ready with out_valid"}, 32'(bus.in_ready), 32'd1);
      check_results(tag, v);
      @(negedge clk);
      check({tag, " out_valid pulse"}, 32'(bus.out_valid), 32'd0);
      check({tag, " ya hold"}, 32'(bus.ya), 32'(v.ya));
   endtask

   vec_t vecs[4];

   initial begin
      vec_t v, v1, v2;
      logic [3:0] ea, eb;
      bit seen_ov;

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      v = mkv(0, 0, 0, 0, 0, 0, 0, 0);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check_results("reset", v);

      vecs[0] = mkv(10, 5, 15, 5, 50, 2, 0, 0);
      vecs[1] = mkv(15, 3, 2, 12, 45, 5, 0, 0);
      vecs[2] = mkv(13, 4, 1, 9, 52, 3, 1, 0);
      vecs[3] = mkv(10, 0, 10, 10, 0, 15, 10, 1);
      for (int i = 0; i < 4; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // reset while a pair is in flight: no result may emerge
      @(negedge clk);
      bus.a = 4'd12;
      bus.b = 4'd5;
      bus.in_valid = 1'b1;
      seen_ov = 1'b0;
      if (RST_DLY == 0) rst = 1'b1;
      for (int i = 1; i <= RST_DLY; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         seen_ov |= bus.out_valid;
         if (i == RST_DLY) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check_results("rst", v);
      for (int i = 0; i < 8; i++) begin
         seen_ov |= bus.out_valid;
         @(negedge clk);
      end
      check("rst no out_valid", 32'(seen_ov), 32'd0);

      for (int a = 10; a <= 15; a++) begin
         for (int b = 0; b <= 5; b++) begin
            ea = 4'(a);
            eb = 4'(b);
            v = mkv(a, b, 32'(4'(ea + eb)), 32'(4'(ea - eb)), a * b,
                    (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0);
            apply(v, $sformatf("sweep %0d/%0d", a, b));
         end
      end

      // back-to-back: second pair held while busy, taken in the out_valid cycle
      v1 = mkv(7, 2, 9, 5, 14, 3, 1, 0);
      v2 = mkv(9, 3, 12, 6, 27, 3, 0, 0);
      @(negedge clk);
      bus.a = v1.a;
      bus.b = v1.b;
      bus.in_valid = 1'b1;
      for (int cyc = 1; cyc <= 2 * LAT + 3; cyc++) begin
         @(negedge clk);
         check($sformatf("b2b out_valid c%0d", cyc), 32'(bus.out_valid),
               (cyc == LAT || cyc == 2 * LAT) ? 32'd1 : 32'd0);
         if (cyc == LAT) begin
            check("b2b in_ready", 32'(bus.in_ready), 32'd1);
            check_results("b2b first", v1);
         end
         if (cyc == 2 * LAT) check_results("b2b second", v2);
         bus.a = v2.a;
         bus.b = v2.b;
         bus.in_valid = (cyc <= LAT);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
